// File: rtl/datapath_pipe_if.sv
// Issue/writeback bundle between the instruction source and the two-stage datapath.
interface datapath_pipe_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             load_en;
  logic [SEL_W-1:0] a_sel;
  logic [SEL_W-1:0] b_sel;
  logic [SEL_W-1:0] dest_sel;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] const_in;
  logic             const_sel;
  logic [WIDTH-1:0] data_in;
  logic             data_sel;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             wb_valid;
  logic [WIDTH-1:0] wb_data;
  logic [SEL_W-1:0] wb_dest;
  logic             z;
  logic             busy;

  modport master (
    output in_valid, load_en, a_sel, b_sel, dest_sel, op_sel,
           const_in, const_sel, data_in, data_sel,
    input  in_ready, a_out, b_out, wb_valid, wb_data, wb_dest, z, busy
  );

  modport slave (
    input  in_valid, load_en, a_sel, b_sel, dest_sel, op_sel,
           const_in, const_sel, data_in, data_sel,
    output in_ready, a_out, b_out, wb_valid, wb_data, wb_dest, z, busy
  );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage register-file/ALU datapath: ISSUE reads and latches operands,
// EX runs the ALU in one cycle or a WIDTH-cycle shift-add multiply, then writes back.
module datapath_pipe #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int SEL_W = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  datapath_pipe_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] rf [NREGS];

  // EX-stage instruction latch
  logic [WIDTH-1:0] a_q, b_q, din_q;
  logic [SEL_W-1:0] dest_q;
  logic [3:0]       op_q;
  logic             ld_q, dsel_q;

  // shift-add multiplier state
  logic [WIDTH-1:0] acc, mcd, mpl;
  logic [CNT_W-1:0] cnt;

  logic             wb_valid_q, z_q;
  logic [WIDTH-1:0] wb_data_q;
  logic [SEL_W-1:0] wb_dest_q;

  logic             done, issue, fwd;
  logic [WIDTH-1:0] f, acc_nxt, wb_val, rd_a, rd_b;

  always_comb begin
    acc_nxt = acc + (mpl[0] ? mcd : '0);
    case (op_q)
      4'd0:    f = a_q + b_q;
      4'd1:    f = a_q - b_q;
      4'd2:    f = a_q & b_q;
      4'd3:    f = a_q | b_q;
      4'd4:    f = a_q ^ b_q;
      4'd5:    f = ~a_q;
      4'd6:    f = a_q << 1;
      4'd7:    f = a_q >> 1;
      4'd8:    f = b_q;
      OP_MUL:  f = acc_nxt;
      default: f = a_q;
    endcase
    done   = (state == EXEC) || (state == MUL && cnt == MUL_LAST);
    wb_val = dsel_q ? din_q : f;
    issue  = bus.in_valid && ((state == IDLE) || done);
    // The value being written this edge bypasses the register file.
    fwd    = done && ld_q;
    rd_a   = (fwd && dest_q == bus.a_sel) ? wb_val : rf[bus.a_sel];
    rd_b   = (fwd && dest_q == bus.b_sel) ? wb_val : rf[bus.b_sel];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      a_q        <= '0;
      b_q        <= '0;
      din_q      <= '0;
      dest_q     <= '0;
      op_q       <= '0;
      ld_q       <= 1'b0;
      dsel_q     <= 1'b0;
      acc        <= '0;
      mcd        <= '0;
      mpl        <= '0;
      cnt        <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_dest_q  <= '0;
      z_q        <= 1'b0;
    end else begin
      wb_valid_q <= done;
      if (done) begin
        wb_data_q <= wb_val;
        wb_dest_q <= dest_q;
        z_q       <= (f == '0);
        if (ld_q) rf[dest_q] <= wb_val;
      end
      if (state == MUL) begin
        acc <= acc_nxt;
        mcd <= mcd << 1;
        mpl <= mpl >> 1;
        cnt <= cnt + 1'b1;
      end
      // A new issue on the completion edge chains straight into EX.
      if (issue) begin
        a_q    <= rd_a;
        b_q    <= bus.const_sel ? bus.const_in : rd_b;
        din_q  <= bus.data_in;
        dest_q <= bus.dest_sel;
        op_q   <= bus.op_sel;
        ld_q   <= bus.load_en;
        dsel_q <= bus.data_sel;
        acc    <= '0;
        mcd    <= rd_a;
        mpl    <= bus.const_sel ? bus.const_in : rd_b;
        cnt    <= '0;
        state  <= (bus.op_sel == OP_MUL) ? MUL : EXEC;
      end else if (done) begin
        state <= IDLE;
      end
    end
  end

  assign bus.in_ready = (state == IDLE) || done;
  assign bus.a_out    = a_q;
  assign bus.b_out    = b_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_dest  = wb_dest_q;
  assign bus.z        = z_q;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: drives and samples on the falling edge.
module tb_datapath_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  datapath_pipe_if #(.WIDTH(16), .SEL_W(4)) bus ();
  datapath_pipe #(.WIDTH(16), .NREGS(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [15:0] k, input logic cs,
                       input logic ld, input logic ds, input logic [15:0] di);
    bus.in_valid  = 1'b1;
    bus.op_sel    = op;
    bus.a_sel     = a;
    bus.b_sel     = b;
    bus.dest_sel  = d;
    bus.const_in  = k;
    bus.const_sel = cs;
    bus.load_en   = ld;
    bus.data_sel  = ds;
    bus.data_in   = di;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    drive(4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.wb_valid !== 1'b0 || bus.z !== 1'b0) begin errors++; $display("FAIL reset_wb_z got %b/%b want 0/0", bus.wb_valid, bus.z); end
    checks++; if (bus.a_out !== 16'h0 || bus.b_out !== 16'h0 || bus.wb_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", bus.a_out, bus.b_out, bus.wb_data); end
  endtask

  task automatic test_const();
    drive(4'd8, 4'd0, 4'd0, 4'd1, 16'd5, 1'b1, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.b_out !== 16'd5) begin errors++; $display("FAIL const_issue busy/b_out got %b/%0d want 1/5", bus.busy, bus.b_out); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL const_ready got %b want 1", bus.in_ready); end
    drive(4'd8, 4'd0, 4'd0, 4'd2, 16'd7, 1'b1, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'd5 || bus.wb_dest !== 4'd1 || bus.z !== 1'b0) begin errors++; $display("FAIL const_wb5 got v=%b d=%0d dst=%0d z=%b want 1/5/1/0", bus.wb_valid, bus.wb_data, bus.wb_dest, bus.z); end
    idle();
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'd7 || bus.wb_dest !== 4'd2 || bus.z !== 1'b0) begin errors++; $display("FAIL const_wb7 got v=%b d=%0d dst=%0d z=%b want 1/7/2/0", bus.wb_valid, bus.wb_data, bus.wb_dest, bus.z); end
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL const_drain got v=%b busy=%b want 0/0", bus.wb_valid, bus.busy); end
  endtask

  task automatic test_back_to_back();
    drive(4'd0, 4'd1, 4'd2, 4'd3, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    drive(4'd1, 4'd3, 4'd2, 4'd4, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_stall got in_ready %b want 1", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'd12 || bus.wb_dest !== 4'd3) begin errors++; $display("FAIL b2b_r3 got v=%b d=%0d dst=%0d want 1/12/3", bus.wb_valid, bus.wb_data, bus.wb_dest); end
    checks++; if (bus.a_out !== 16'd12 || bus.b_out !== 16'd7) begin errors++; $display("FAIL b2b_fwd got a=%0d b=%0d want 12/7", bus.a_out, bus.b_out); end
    idle();
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'd5 || bus.wb_dest !== 4'd4) begin errors++; $display("FAIL b2b_r4 got v=%b d=%0d dst=%0d want 1/5/4", bus.wb_valid, bus.wb_data, bus.wb_dest); end
  endtask

  task automatic test_zero();
    drive(4'd1, 4'd1, 4'd1, 4'd5, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    drive(4'd8, 4'd0, 4'd0, 4'd7, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.wb_data !== 16'h0 || bus.z !== 1'b1) begin errors++; $display("FAIL zero_sub got d=%h z=%b want 0000/1", bus.wb_data, bus.z); end
    drive(4'd0, 4'd7, 4'd0, 4'd8, 16'd1, 1'b1, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.wb_data !== 16'hFFFF || bus.z !== 1'b0) begin errors++; $display("FAIL zero_ffff got d=%h z=%b want ffff/0", bus.wb_data, bus.z); end
    idle();
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'h0 || bus.z !== 1'b1) begin errors++; $display("FAIL zero_wrap got v=%b d=%h z=%b want 1/0000/1", bus.wb_valid, bus.wb_data, bus.z); end
  endtask

  task automatic test_mul();
    int stalled;
    drive(4'd9, 4'd1, 4'd2, 4'd6, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    drive(4'd0, 4'd6, 4'd1, 4'd9, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    stalled = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.in_ready === 1'b0 && bus.wb_valid === 1'b0 && bus.busy === 1'b1) stalled++;
      @(negedge clk);
    end
    checks++; if (stalled !== 15) begin errors++; $display("FAIL mul_stall got %0d stalled cycles want 15", stalled); end
    checks++; if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mul_last_cycle got rdy=%b v=%b want 1/0", bus.in_ready, bus.wb_valid); end
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'd35 || bus.wb_dest !== 4'd6 || bus.z !== 1'b0) begin errors++; $display("FAIL mul_wb got v=%b d=%0d dst=%0d z=%b want 1/35/6/0", bus.wb_valid, bus.wb_data, bus.wb_dest, bus.z); end
    checks++; if (bus.a_out !== 16'd35 || bus.busy !== 1'b1) begin errors++; $display("FAIL mul_dep_fwd got a=%0d busy=%b want 35/1", bus.a_out, bus.busy); end
    idle();
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'd40 || bus.wb_dest !== 4'd9) begin errors++; $display("FAIL mul_dep_wb got v=%b d=%0d dst=%0d want 1/40/9", bus.wb_valid, bus.wb_data, bus.wb_dest); end
  endtask

  task automatic test_data_sel();
    // F = r1 - r1 = 0 while the written value is memory data
    drive(4'd1, 4'd1, 4'd1, 4'd10, 16'h0, 1'b0, 1'b1, 1'b1, 16'hBEEF);
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'hBEEF || bus.z !== 1'b1) begin errors++; $display("FAIL dsel_wb got v=%b d=%h z=%b want 1/beef/1", bus.wb_valid, bus.wb_data, bus.z); end
    drive(4'd10, 4'd10, 4'd0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.a_out !== 16'hBEEF) begin errors++; $display("FAIL dsel_rf got r10=%h want beef", bus.a_out); end
    drive(4'd0, 4'd1, 4'd2, 4'd11, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234);
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'h1234 || bus.z !== 1'b0) begin errors++; $display("FAIL noload_wb got v=%b d=%h z=%b want 1/1234/0", bus.wb_valid, bus.wb_data, bus.z); end
    drive(4'd10, 4'd11, 4'd0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    idle();
    checks++; if (bus.a_out !== 16'h0) begin errors++; $display("FAIL noload_rf got r11=%h want 0000", bus.a_out); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    drive(4'd9, 4'd1, 4'd2, 4'd12, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mul_state got v=%b busy=%b rdy=%b want 0/0/1", bus.wb_valid, bus.busy, bus.in_ready); end
    checks++; if (bus.z !== 1'b0 || bus.a_out !== 16'h0 || bus.wb_data !== 16'h0) begin errors++; $display("FAIL rst_mul_regs got z=%b a=%h d=%h want 0/0000/0000", bus.z, bus.a_out, bus.wb_data); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wb_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mul_nowb got %0d pulses want 0", seen); end
    drive(4'd10, 4'd1, 4'd2, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    idle();
    checks++; if (bus.a_out !== 16'h0 || bus.b_out !== 16'h0) begin errors++; $display("FAIL rst_mul_rf got r1=%h r2=%h want 0000/0000", bus.a_out, bus.b_out); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_const();
    test_back_to_back();
    test_zero();
    test_mul();
    test_data_sel();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
